// File: rtl/game_pkg.sv
// Shared state encodings, default round/timing constants and score saturation
// for the block-shooter round sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_FLASH = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam logic [7:0]  DEF_BLOCK_HP    = 8'hB0;
    localparam logic [7:0]  DEF_HP_STEP     = 8'h10;
    localparam logic [15:0] DEF_ROUND_TICKS = 16'd3000;
    localparam logic [7:0]  DEF_FLASH_TICKS = 8'd30;
    localparam logic [7:0]  DEF_CLEAR_TICKS = 8'd90;
    localparam logic [3:0]  DEF_MAX_LEVEL   = 4'd9;
    localparam logic [11:0] SCORE_MAX       = 12'd4095;

    function automatic logic [11:0] score_add(input logic [11:0] s, input logic [3:0] lvl);
        logic [12:0] sum;
        sum = {1'b0, s} + {9'd0, lvl};
        return sum[12] ? SCORE_MAX : sum[11:0];
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Key synchroniser: 2-FF sync of an active-low key, one-tick press pulse on 1->0.
// Latency: pulse visible two game_clk edges after the key falls.
// Backpressure: none; a press is a single-tick event and is never held.
module key_edge_det (
    input  logic game_clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    // [0],[1] synchroniser stages, [2] previous synchronised level
    logic [2:0] sh;

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset)
            sh <= 3'b111;
        else
            sh <= {sh[1:0], key_n};
    end

    assign press = sh[2] & ~sh[1];

endmodule

// File: rtl/game_seq_ctrl.sv
// Round sequencer: phase FSM, block health, score, level, round timer; optional pause (GAME_PAUSE_EN).
// Latency: one game_clk per transition, presses act three edges after the key falls.
// Backpressure: none; hits outside PLAY (and during flash/pause) are dropped.
module game_seq_ctrl
    import game_pkg::*;
#(
    parameter logic [7:0]  BLOCK_HP    = DEF_BLOCK_HP,
    parameter logic [7:0]  HP_STEP     = DEF_HP_STEP,
    parameter logic [15:0] ROUND_TICKS = DEF_ROUND_TICKS,
    parameter logic [7:0]  FLASH_TICKS = DEF_FLASH_TICKS,
    parameter logic [7:0]  CLEAR_TICKS = DEF_CLEAR_TICKS,
    parameter logic [3:0]  MAX_LEVEL   = DEF_MAX_LEVEL
) (
    input  logic        game_clk,
    input  logic        reset,
    input  logic        start_n,
`ifdef GAME_PAUSE_EN
    input  logic        pause_n,
`endif
    input  logic        hit,
    output logic        run_en,
    output logic        flash,
    output logic [7:0]  block_hp,
    output logic [3:0]  level,
    output logic [11:0] score,
    output logic [15:0] time_left,
    output logic [2:0]  state
);

    state_t     st;
    logic [7:0] cnt;
    logic       start_press;
    logic [7:0] hp_after_hit;

    key_edge_det u_start_key (
        .game_clk (game_clk),
        .reset    (reset),
        .key_n    (start_n),
        .press    (start_press)
    );

`ifdef GAME_PAUSE_EN
    logic   pause_press;
    state_t saved_st;

    key_edge_det u_pause_key (
        .game_clk (game_clk),
        .reset    (reset),
        .key_n    (pause_n),
        .press    (pause_press)
    );
`endif

    assign hp_after_hit = (block_hp > HP_STEP) ? (block_hp - HP_STEP) : 8'd0;
    assign state        = st;

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            st        <= ST_IDLE;
            run_en    <= 1'b0;
            flash     <= 1'b0;
            block_hp  <= BLOCK_HP;
            level     <= 4'd1;
            score     <= 12'd0;
            time_left <= ROUND_TICKS;
            cnt       <= 8'd0;
`ifdef GAME_PAUSE_EN
            saved_st  <= ST_PLAY;
`endif
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start_press) begin
                        st        <= ST_PLAY;
                        run_en    <= 1'b1;
                        level     <= 4'd1;
                        score     <= 12'd0;
                        block_hp  <= BLOCK_HP;
                        time_left <= ROUND_TICKS;
                    end
                end
                ST_PLAY: begin
`ifdef GAME_PAUSE_EN
                    if (pause_press) begin
                        saved_st <= ST_PLAY;
                        st       <= ST_PAUSE;
                        run_en   <= 1'b0;
                    end else
`endif
                    // A hit on the last timer tick still scores and wins the tick
                    if (hit) begin
                        block_hp  <= hp_after_hit;
                        score     <= score_add(score, level);
                        time_left <= (time_left != 16'd0) ? time_left - 16'd1 : 16'd0;
                        if (hp_after_hit == 8'd0) begin
                            st     <= ST_CLEAR;
                            cnt    <= CLEAR_TICKS;
                            run_en <= 1'b0;
                        end else begin
                            st    <= ST_FLASH;
                            cnt   <= FLASH_TICKS;
                            flash <= 1'b1;
                        end
                    end else if (time_left <= 16'd1) begin
                        time_left <= 16'd0;
                        st        <= ST_OVER;
                        run_en    <= 1'b0;
                    end else begin
                        time_left <= time_left - 16'd1;
                    end
                end
                ST_FLASH: begin
`ifdef GAME_PAUSE_EN
                    if (pause_press) begin
                        saved_st <= ST_FLASH;
                        st       <= ST_PAUSE;
                        run_en   <= 1'b0;
                        flash    <= 1'b0;
                    end else
`endif
                    if (time_left <= 16'd1) begin
                        time_left <= 16'd0;
                        st        <= ST_OVER;
                        run_en    <= 1'b0;
                        flash     <= 1'b0;
                    end else begin
                        time_left <= time_left - 16'd1;
                        if (cnt == 8'd1) begin
                            st    <= ST_PLAY;
                            flash <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (cnt == 8'd1) begin
                        if (level == MAX_LEVEL) begin
                            st <= ST_OVER;
                        end else begin
                            st        <= ST_PLAY;
                            run_en    <= 1'b1;
                            level     <= level + 4'd1;
                            block_hp  <= BLOCK_HP;
                            time_left <= ROUND_TICKS;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_OVER: begin
                    // Score stays visible until the next game starts
                    if (start_press) begin
                        st        <= ST_IDLE;
                        run_en    <= 1'b0;
                        flash     <= 1'b0;
                        block_hp  <= BLOCK_HP;
                        level     <= 4'd1;
                        time_left <= ROUND_TICKS;
                        cnt       <= 8'd0;
                    end
                end
`ifdef GAME_PAUSE_EN
                ST_PAUSE: begin
                    if (pause_press) begin
                        st     <= saved_st;
                        run_en <= 1'b1;
                        flash  <= (saved_st == ST_FLASH);
                    end
                end
`endif
                default: begin
                    st     <= ST_IDLE;
                    run_en <= 1'b0;
                    flash  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl: reset, start, hit/flash, level clear,
// timeout, final-tick hit, async reset and (with GAME_PAUSE_EN) pause.
module tb_game_seq_ctrl;

    logic        game_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        start_n  = 1'b1;
    logic        hit      = 1'b0;
`ifdef GAME_PAUSE_EN
    logic        pause_n  = 1'b1;
`endif
    logic        run_en;
    logic        flash;
    logic [7:0]  block_hp;
    logic [3:0]  level;
    logic [11:0] score;
    logic [15:0] time_left;
    logic [2:0]  state;

    int passed = 0;
    int total  = 0;

    game_seq_ctrl dut (
        .game_clk  (game_clk),
        .reset     (reset),
        .start_n   (start_n),
`ifdef GAME_PAUSE_EN
        .pause_n   (pause_n),
`endif
        .hit       (hit),
        .run_en    (run_en),
        .flash     (flash),
        .block_hp  (block_hp),
        .level     (level),
        .score     (score),
        .time_left (time_left),
        .state     (state)
    );

    always #5 game_clk = ~game_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge game_clk);
        #1;
    endtask

    task automatic do_press();
        start_n = 1'b0;
        tick(3);
        start_n = 1'b1;
    endtask

    task automatic do_hit();
        hit = 1'b1;
        tick(1);
        hit = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        reset = 1'b0;
        tick(1);
        total++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
        total++; if (run_en !== 1'b0 || flash !== 1'b0) $display("FAIL reset_run_flash got %b%b want 00", run_en, flash); else passed++;
        total++; if (block_hp !== 8'hB0) $display("FAIL reset_hp got %h want b0", block_hp); else passed++;
        total++; if (level !== 4'd1 || score !== 12'd0) $display("FAIL reset_lvl_score got %0d/%0d want 1/0", level, score); else passed++;
        total++; if (time_left !== 16'd3000) $display("FAIL reset_time got %0d want 3000", time_left); else passed++;
    endtask

    task automatic test_start();
        start_n = 1'b0;
        tick(2);
        total++; if (state !== 3'd0) $display("FAIL start_sync_delay got %0d want 0", state); else passed++;
        tick(1);
        start_n = 1'b1;
        total++; if (state !== 3'd1 || run_en !== 1'b1) $display("FAIL start_play got st=%0d run=%b want 1/1", state, run_en); else passed++;
        total++; if (block_hp !== 8'hB0 || level !== 4'd1) $display("FAIL start_hp_lvl got %h/%0d want b0/1", block_hp, level); else passed++;
        total++; if (time_left !== 16'd3000) $display("FAIL start_time got %0d want 3000", time_left); else passed++;
        tick(1);
        total++; if (time_left !== 16'd2999) $display("FAIL play_decrement got %0d want 2999", time_left); else passed++;
    endtask

    task automatic test_hit_flash();
        do_hit();
        total++; if (block_hp !== 8'hA0 || score !== 12'd1) $display("FAIL hit_hp_score got %h/%0d want a0/1", block_hp, score); else passed++;
        total++; if (state !== 3'd2 || flash !== 1'b1 || run_en !== 1'b1) $display("FAIL hit_flash got st=%0d fl=%b run=%b want 2/1/1", state, flash, run_en); else passed++;
        tick(1);
        do_hit();
        total++; if (block_hp !== 8'hA0 || score !== 12'd1) $display("FAIL flash_hit_ignored got %h/%0d want a0/1", block_hp, score); else passed++;
        tick(27);
        total++; if (flash !== 1'b1 || state !== 3'd2) $display("FAIL flash_tick30 got fl=%b st=%0d want 1/2", flash, state); else passed++;
        tick(1);
        total++; if (flash !== 1'b0 || state !== 3'd1) $display("FAIL flash_end got fl=%b st=%0d want 0/1", flash, state); else passed++;
        total++; if (time_left !== 16'd2968) $display("FAIL flash_timer got %0d want 2968", time_left); else passed++;
    endtask

    task automatic test_level_clear();
        logic [7:0] exp_hp;
        exp_hp = 8'hA0;
        for (int i = 0; i < 9; i++) begin
            do_hit();
            exp_hp = exp_hp - 8'h10;
            total++; if (block_hp !== exp_hp) $display("FAIL spaced_hit%0d got %h want %h", i, block_hp, exp_hp); else passed++;
            tick(30);
        end
        do_hit();
        total++; if (state !== 3'd3 || block_hp !== 8'h00 || run_en !== 1'b0) $display("FAIL clear_enter got st=%0d hp=%h run=%b want 3/00/0", state, block_hp, run_en); else passed++;
        total++; if (score !== 12'd11) $display("FAIL clear_score got %0d want 11", score); else passed++;
        do_hit();
        tick(88);
        total++; if (state !== 3'd3 || time_left !== 16'd2688 || score !== 12'd11) $display("FAIL clear_hold got st=%0d t=%0d sc=%0d want 3/2688/11", state, time_left, score); else passed++;
        tick(1);
        total++; if (state !== 3'd1 || level !== 4'd2 || run_en !== 1'b1) $display("FAIL clear_next got st=%0d lvl=%0d run=%b want 1/2/1", state, level, run_en); else passed++;
        total++; if (block_hp !== 8'hB0 || time_left !== 16'd3000) $display("FAIL clear_reload got %h/%0d want b0/3000", block_hp, time_left); else passed++;
        do_hit();
        total++; if (score !== 12'd13 || block_hp !== 8'hA0) $display("FAIL level2_hit got %0d/%h want 13/a0", score, block_hp); else passed++;
        tick(30);
    endtask

    task automatic test_timeout();
        tick(2968);
        total++; if (state !== 3'd1 || time_left !== 16'd1) $display("FAIL timeout_last got st=%0d t=%0d want 1/1", state, time_left); else passed++;
        tick(1);
        total++; if (state !== 3'd4 || time_left !== 16'd0 || run_en !== 1'b0) $display("FAIL timeout_over got st=%0d t=%0d run=%b want 4/0/0", state, time_left, run_en); else passed++;
        do_hit();
        tick(5);
        total++; if (level !== 4'd2 || score !== 12'd13 || block_hp !== 8'hA0) $display("FAIL over_hold got %0d/%0d/%h want 2/13/a0", level, score, block_hp); else passed++;
        do_press();
        total++; if (state !== 3'd0 || level !== 4'd1 || block_hp !== 8'hB0 || time_left !== 16'd3000) $display("FAIL over_to_idle got st=%0d lvl=%0d hp=%h t=%0d want 0/1/b0/3000", state, level, block_hp, time_left); else passed++;
        total++; if (score !== 12'd13) $display("FAIL idle_score_held got %0d want 13", score); else passed++;
        do_hit();
        total++; if (block_hp !== 8'hB0 || score !== 12'd13) $display("FAIL idle_hit_ignored got %h/%0d want b0/13", block_hp, score); else passed++;
        tick(2);
    endtask

    task automatic test_final_tick_hit();
        do_press();
        total++; if (state !== 3'd1 || score !== 12'd0) $display("FAIL restart got st=%0d sc=%0d want 1/0", state, score); else passed++;
        tick(2999);
        total++; if (time_left !== 16'd1) $display("FAIL final_tick_time got %0d want 1", time_left); else passed++;
        do_hit();
        total++; if (state !== 3'd2 || block_hp !== 8'hA0 || score !== 12'd1 || time_left !== 16'd0) $display("FAIL final_hit got st=%0d hp=%h sc=%0d t=%0d want 2/a0/1/0", state, block_hp, score, time_left); else passed++;
        tick(1);
        total++; if (state !== 3'd4 || flash !== 1'b0 || run_en !== 1'b0) $display("FAIL final_over got st=%0d fl=%b run=%b want 4/0/0", state, flash, run_en); else passed++;
        tick(2);
    endtask

    task automatic test_async_reset();
        do_press();
        tick(2);
        do_press();
        tick(5);
        do_hit();
        tick(3);
        #3 reset = 1'b1;
        #1;
        total++; if (state !== 3'd0 || run_en !== 1'b0 || flash !== 1'b0) $display("FAIL async_reset_ctl got st=%0d run=%b fl=%b want 0/0/0", state, run_en, flash); else passed++;
        total++; if (block_hp !== 8'hB0 || score !== 12'd0 || time_left !== 16'd3000 || level !== 4'd1) $display("FAIL async_reset_data got hp=%h sc=%0d t=%0d lvl=%0d want b0/0/3000/1", block_hp, score, time_left, level); else passed++;
        reset = 1'b0;
        tick(3);
    endtask

`ifdef GAME_PAUSE_EN
    task automatic test_pause();
        int n;
        do_press();
        tick(2);
        do_hit();
        tick(18);
        pause_n = 1'b0;
        tick(3);
        pause_n = 1'b1;
        total++; if (state !== 3'd5 || run_en !== 1'b0 || time_left !== 16'd2977) $display("FAIL pause_enter got st=%0d run=%b t=%0d want 5/0/2977", state, run_en, time_left); else passed++;
        do_hit();
        tick(493);
        total++; if (state !== 3'd5 || time_left !== 16'd2977 || block_hp !== 8'hA0) $display("FAIL pause_frozen got st=%0d t=%0d hp=%h want 5/2977/a0", state, time_left, block_hp); else passed++;
        pause_n = 1'b0;
        tick(3);
        pause_n = 1'b1;
        total++; if (state !== 3'd2 || flash !== 1'b1 || time_left !== 16'd2977) $display("FAIL pause_resume got st=%0d fl=%b t=%0d want 2/1/2977", state, flash, time_left); else passed++;
        n = 0;
        for (int i = 0; i < 50 && flash === 1'b1; i++) begin
            n++;
            tick(1);
        end
        total++; if (n !== 10) $display("FAIL pause_flash_rest got %0d want 10", n); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_hit_flash();
        test_level_clear();
        test_timeout();
        test_final_tick_hit();
        test_async_reset();
`ifdef GAME_PAUSE_EN
        test_pause();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
